// File: rtl/stall_pipe_n.sv
// ============================================================================
// stall_pipe_n : two-lane three-operand adder pipeline, DEPTH stages, with
//                valid/ready, stall, flush, occupancy and a sticky lane check.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module stall_pipe_n #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       inj,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err
);

  localparam int OW = $clog2(DEPTH+1);

  generate
    if (DEPTH < 2) begin : g_depth_check
      $error("stall_pipe_n: DEPTH must be at least 2");
    end
  endgenerate

  logic [DEPTH:1]    r_v;
  logic [WIDTH-1:0]  r_ax, r_ay, r_bx, r_by;
  logic [WIDTH-1:0]  r_asum [2:DEPTH];
  logic [WIDTH-1:0]  r_bsum [2:DEPTH];
  logic [OW-1:0]     r_occ;
  logic              r_err;
  logic              r_inj_seen;

  logic              w_adv;
  logic              w_inc;
  logic              w_dec;
  logic              w_mis;
  logic [WIDTH-1:0]  w_s1a;
  logic [WIDTH-1:0]  w_s1b;
  logic [WIDTH-1:0]  w_injmask;

  assign w_adv     = !stall && !flush && (!r_v[DEPTH] || out_ready);
  assign w_inc     = w_adv && in_valid;
  assign w_dec     = w_adv && r_v[DEPTH];
  assign w_s1a     = r_ax + r_ay;
  assign w_s1b     = r_bx + r_by;
  assign w_injmask = {{(WIDTH-1){1'b0}}, inj};

  assign in_ready  = w_adv;
  assign out_valid = r_v[DEPTH];
  assign out_data  = r_asum[DEPTH];
  assign occupancy = r_occ;
  assign err       = r_err;

  // Lanes are compared on registered state only, so err lags the bad state by one edge.
  always_comb begin
    w_mis = r_v[1] && (w_s1a != w_s1b);
    for (int k = 2; k <= DEPTH; k++) begin
      if (r_v[k] && (r_asum[k] != r_bsum[k])) begin
        w_mis = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v        <= '0;
      r_ax       <= '0;
      r_ay       <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_occ      <= '0;
      r_err      <= 1'b0;
      r_inj_seen <= 1'b0;
      for (int k = 2; k <= DEPTH; k++) begin
        r_asum[k] <= '0;
        r_bsum[k] <= '0;
      end
    end else begin
      r_inj_seen <= r_inj_seen | inj;
      r_err      <= r_err | w_mis;
      if (flush) begin
        r_v   <= '0;
        r_occ <= '0;
      end else if (w_adv) begin
        r_v       <= {r_v[DEPTH-1:1], in_valid};
        r_ax      <= a + b;
        r_ay      <= c;
        r_bx      <= (a + c) ^ w_injmask;
        r_by      <= b;
        r_asum[2] <= w_s1a;
        r_bsum[2] <= w_s1b;
        for (int k = 3; k <= DEPTH; k++) begin
          r_asum[k] <= r_asum[k-1];
          r_bsum[k] <= r_bsum[k-1];
        end
        if (w_inc && !w_dec) begin
          r_occ <= r_occ + OW'(1);
        end else if (!w_inc && w_dec) begin
          r_occ <= r_occ - OW'(1);
        end
      end
    end
  end

  // Equivalence properties; only meaningful once out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (r_inj_seen || !w_mis)
        else $error("stall_pipe_n: lane divergence without injection");
      assert (32'(r_occ) == 32'($countones(r_v)))
        else $error("stall_pipe_n: occupancy differs from valid count");
    end
  end

endmodule

`default_nettype wire
